// File: rtl/output_fifo_drain.sv
// rtl/output_fifo_drain.sv - drains the 8-bit output FIFO into 32-bit stream words
//
// Pops bytes from a non-show-ahead FIFO (data valid the cycle after the read
// strobe), packs four bytes per word (first byte in [7:0]), and presents each
// word on a valid/ready master stream with lane enables and a last-word tag.
// A frame is started by start_i and ends after byte_total_i+1 bytes; done_o
// pulses one cycle after the final word is accepted.
//
// Ports:
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   start_i, byte_total_i frame start pulse and [bytes-1] for the frame
//   fifo_rd_data_i        FIFO q (valid the cycle after fifo_rd_en_o)
//   fifo_rd_en_o          FIFO read request
//   fifo_empty_i          FIFO empty flag
//   fifo_data_count_i     FIFO fill level (status only)
//   m_data_o, m_byte_en_o packed word and its valid byte lanes
//   m_valid_o, m_ready_i  word handshake
//   m_last_o              final word of the frame
//   busy_o, done_o        frame in progress / one-cycle completion pulse
module output_fifo_drain #(
    parameter int FIFO_DEPTH = 1024,
    parameter int CNT_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          start_i,
    input  logic [CNT_W-1:0]              byte_total_i,
    input  logic [7:0]                    fifo_rd_data_i,
    output logic                          fifo_rd_en_o,
    input  logic                          fifo_empty_i,
    input  logic [$clog2(FIFO_DEPTH)-1:0] fifo_data_count_i,
    output logic [31:0]                   m_data_o,
    output logic [3:0]                    m_byte_en_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic                          m_last_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] total;
    logic [CNT_W:0]   req_cnt;
    logic [CNT_W:0]   rcv_cnt;
    logic [2:0]       lane;
    logic             inflight;
    logic [3:0][7:0]  pack;

    logic [CNT_W:0]   total_p1;
    logic [CNT_W:0]   rcv_nxt;
    logic [2:0]       lane_nxt;
    logic [2:0]       occ_after;
    logic [3:0][7:0]  pack_nxt;
    logic [3:0]       be_nxt;
    logic             out_free;
    logic             word_ready;
    logic             xfer;
    logic             hs;

    // Fill level is informational only; flow control uses fifo_empty_i.
    logic unused_count;
    assign unused_count = ^fifo_data_count_i;

    assign busy_o = (state != ST_IDLE);

    always_comb begin
        total_p1 = {1'b0, total} + {{CNT_W{1'b0}}, 1'b1};
        lane_nxt = lane + {2'b00, inflight};
        rcv_nxt  = rcv_cnt + {{CNT_W{1'b0}}, inflight};
        pack_nxt = pack;
        if (inflight) begin
            pack_nxt[lane[1:0]] = fifo_rd_data_i;
        end
        out_free   = !m_valid_o || m_ready_i;
        hs         = m_valid_o && m_ready_i;
        // A word completes on the cycle its final byte lands, so the byte
        // arriving this cycle goes straight into the output register.
        word_ready = (lane_nxt == 3'd4) ||
                     ((rcv_nxt == total_p1) && (lane_nxt != 3'd0));
        xfer       = (state != ST_IDLE) && word_ready && out_free;
        // Lanes still occupied after this cycle; a new read is only issued if
        // its byte will have a free lane when it arrives, so nothing is lost
        // while the sink stalls and back-to-back reads continue across words.
        occ_after  = xfer ? 3'd0 : lane_nxt;
        fifo_rd_en_o = (state == ST_RUN) && !fifo_empty_i &&
                       (req_cnt <= {1'b0, total}) && (occ_after < 3'd4);
        case (lane_nxt)
            3'd1:    be_nxt = 4'b0001;
            3'd2:    be_nxt = 4'b0011;
            3'd3:    be_nxt = 4'b0111;
            default: be_nxt = 4'b1111;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            total       <= '0;
            req_cnt     <= '0;
            rcv_cnt     <= '0;
            lane        <= '0;
            inflight    <= 1'b0;
            pack        <= '0;
            m_data_o    <= '0;
            m_byte_en_o <= '0;
            m_valid_o   <= 1'b0;
            m_last_o    <= 1'b0;
            done_o      <= 1'b0;
        end else if (start_i) begin
            // Also aborts any frame in flight: its pending byte and word vanish.
            state       <= ST_RUN;
            total       <= byte_total_i;
            req_cnt     <= '0;
            rcv_cnt     <= '0;
            lane        <= '0;
            inflight    <= 1'b0;
            pack        <= '0;
            m_data_o    <= '0;
            m_byte_en_o <= '0;
            m_valid_o   <= 1'b0;
            m_last_o    <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o   <= 1'b0;
            inflight <= fifo_rd_en_o;
            rcv_cnt  <= rcv_nxt;
            if (fifo_rd_en_o) begin
                req_cnt <= req_cnt + {{CNT_W{1'b0}}, 1'b1};
            end

            if (xfer) begin
                // pack is cleared here, so unused lanes of a short word read 0.
                m_data_o    <= pack_nxt;
                m_byte_en_o <= be_nxt;
                m_last_o    <= (rcv_nxt == total_p1);
                m_valid_o   <= 1'b1;
                lane        <= '0;
                pack        <= '0;
            end else begin
                lane <= lane_nxt;
                pack <= pack_nxt;
                if (hs) begin
                    m_valid_o <= 1'b0;
                    m_last_o  <= 1'b0;
                end
            end

            case (state)
                ST_RUN: begin
                    if (req_cnt == total_p1) begin
                        state <= ST_DRAIN;
                    end
                end
                default: begin
                end
            endcase

            if ((state != ST_IDLE) && hs && m_last_o) begin
                state  <= ST_IDLE;
                done_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_output_fifo_drain.sv
// tb/tb_output_fifo_drain.sv - self-checking bench for output_fifo_drain
module tb_output_fifo_drain;

    localparam int CNT_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_n_i = 1'b0;
    logic             start_i = 1'b0;
    logic [CNT_W-1:0] byte_total_i = '0;
    logic [7:0]       fifo_rd_data_i = 8'h00;
    logic             fifo_rd_en_o;
    logic             fifo_empty_i = 1'b1;
    logic [9:0]       fifo_data_count_i = '0;
    logic [31:0]      m_data_o;
    logic [3:0]       m_byte_en_o;
    logic             m_valid_o;
    logic             m_ready_i = 1'b0;
    logic             m_last_o;
    logic             busy_o;
    logic             done_o;

    always #5 clk_i = ~clk_i;

    output_fifo_drain #(.FIFO_DEPTH(1024), .CNT_W(CNT_W)) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .start_i           (start_i),
        .byte_total_i      (byte_total_i),
        .fifo_rd_data_i    (fifo_rd_data_i),
        .fifo_rd_en_o      (fifo_rd_en_o),
        .fifo_empty_i      (fifo_empty_i),
        .fifo_data_count_i (fifo_data_count_i),
        .m_data_o          (m_data_o),
        .m_byte_en_o       (m_byte_en_o),
        .m_valid_o         (m_valid_o),
        .m_ready_i         (m_ready_i),
        .m_last_o          (m_last_o),
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0]  fq[$];
    logic [7:0]  exp_bytes[$];
    logic        empty_gate = 1'b0;
    logic        toggle_empty = 1'b0;
    logic        rand_ready = 1'b0;
    logic        hold_en = 1'b1;

    logic        rd_prev = 1'b0;
    int          rd_count = 0;
    int          done_count = 0;
    int          empty_viol = 0;
    int          hold_viol = 0;
    logic        held_v = 1'b0;
    logic [36:0] held = '0;
    logic [31:0] got_data[$];
    logic [3:0]  got_be[$];
    logic        got_last[$];

    int got_base = 0;
    int rd_base = 0;
    int done_base = 0;

    always @(negedge clk_i) begin
        rd_prev <= fifo_rd_en_o;
        if (fifo_rd_en_o) rd_count <= rd_count + 1;
        if (fifo_rd_en_o && fifo_empty_i) empty_viol <= empty_viol + 1;
        if (done_o) done_count <= done_count + 1;
        if (hold_en && held_v &&
            ({m_valid_o, m_last_o, m_byte_en_o, m_data_o} !== {1'b1, held}))
            hold_viol <= hold_viol + 1;
        held_v <= m_valid_o && !m_ready_i;
        held   <= {m_last_o, m_byte_en_o, m_data_o};
        if (m_valid_o && m_ready_i) begin
            got_data.push_back(m_data_o);
            got_be.push_back(m_byte_en_o);
            got_last.push_back(m_last_o);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd_empty();
        fifo_empty_i      = (fq.size() == 0) || empty_gate;
        fifo_data_count_i = 10'(fq.size());
    endtask

    // FIFO model: a read seen before the edge delivers its byte just after it.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
            if (rd_prev) begin
                if (fq.size() > 0) fifo_rd_data_i = fq.pop_front();
                else fifo_rd_data_i = 8'h00;
            end
            #1;
            if (rand_ready) m_ready_i = 1'($urandom_range(0, 1));
            if (toggle_empty) empty_gate = ~empty_gate;
            upd_empty();
        end
    endtask

    task automatic fill_random(input int n);
        exp_bytes.delete();
        for (int i = 0; i < n; i++) exp_bytes.push_back(8'($urandom));
    endtask

    task automatic launch(input int total);
        got_base  = got_data.size();
        rd_base   = rd_count;
        done_base = done_count;
        foreach (exp_bytes[i]) fq.push_back(exp_bytes[i]);
        upd_empty();
        byte_total_i = CNT_W'(total);
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k;
        k = 0;
        while (done_count == done_base && k < budget) begin
            step(1);
            k++;
        end
        check({tag, " done_seen"}, 64'(done_count != done_base), 64'd1);
        step(3);
        check({tag, " done_pulses"}, done_count - done_base, 1);
        check({tag, " busy_after"}, busy_o, 1'b0);
    endtask

    // Reference: byte i of the frame goes to word i/4, lane i%4; the final word
    // alone carries last, and lanes past the final byte are zero and disabled.
    task automatic check_words(input string tag);
        int n, nw;
        logic [31:0] d;
        logic [3:0]  be;
        n  = exp_bytes.size();
        nw = (n + 3) / 4;
        check({tag, " word_count"}, got_data.size() - got_base, nw);
        for (int w = 0; w < nw; w++) begin
            d  = '0;
            be = '0;
            for (int j = 0; j < 4; j++) begin
                if (4 * w + j < n) begin
                    d  = d | (32'(exp_bytes[4 * w + j]) << (8 * j));
                    be = be | 4'(1 << j);
                end
            end
            if (got_base + w < got_data.size()) begin
                check($sformatf("%s w%0d data", tag, w), got_data[got_base + w], d);
                check($sformatf("%s w%0d be", tag, w), got_be[got_base + w], be);
                check($sformatf("%s w%0d last", tag, w), got_last[got_base + w], 64'(w == nw - 1));
            end
        end
    endtask

    initial begin
        int k;
        int tot;
        logic [31:0] w0;

        // Reset state
        rst_n_i = 1'b0;
        step(2);
        check("rst m_valid", m_valid_o, 0);
        check("rst m_data", m_data_o, 0);
        check("rst m_byte_en", m_byte_en_o, 0);
        check("rst m_last", m_last_o, 0);
        check("rst busy", busy_o, 0);
        check("rst done", done_o, 0);
        check("rst rd_en", fifo_rd_en_o, 0);
        rst_n_i = 1'b1;
        step(1);

        // A: 8 bytes 01..08, sink always ready
        m_ready_i = 1'b1;
        exp_bytes.delete();
        for (int i = 1; i <= 8; i++) exp_bytes.push_back(8'(i));
        launch(7);
        wait_done(100, "A");
        check_words("A");
        check("A rd_count", rd_count - rd_base, 8);

        // B: 6 bytes A0..A5, partial final word
        exp_bytes.delete();
        for (int i = 0; i < 6; i++) exp_bytes.push_back(8'(8'hA0 + i));
        launch(5);
        wait_done(100, "B");
        check_words("B");

        // C: 16 random bytes, sink stalled for 20 cycles after first valid
        m_ready_i = 1'b0;
        fill_random(16);
        launch(15);
        k = 0;
        while (!m_valid_o && k < 50) begin
            step(1);
            k++;
        end
        check("C valid_seen", m_valid_o, 1);
        w0 = m_data_o;
        step(20);
        check("C held_data", m_data_o, w0);
        check("C word0", w0, {exp_bytes[3], exp_bytes[2], exp_bytes[1], exp_bytes[0]});
        check("C rd_stalled", rd_count - rd_base, 8);
        check("C no_handshake", got_data.size() - got_base, 0);
        m_ready_i = 1'b1;
        wait_done(200, "C");
        check_words("C");
        check("C rd_count", rd_count - rd_base, 16);

        // D: FIFO empty every other cycle, random sink readiness
        tot = int'($urandom_range(20, 40));
        fill_random(tot + 1);
        toggle_empty = 1'b1;
        rand_ready = 1'b1;
        launch(tot);
        wait_done(2000, "D");
        toggle_empty = 1'b0;
        rand_ready = 1'b0;
        empty_gate = 1'b0;
        m_ready_i = 1'b1;
        upd_empty();
        check_words("D");
        check("D rd_count", rd_count - rd_base, tot + 1);

        // E: abort a 64-byte frame after 3 words, then a 4-byte frame
        fill_random(64);
        launch(63);
        k = 0;
        while (got_data.size() - got_base < 3 && k < 200) begin
            step(1);
            k++;
        end
        m_ready_i = 1'b0;
        empty_gate = 1'b1;
        hold_en = 1'b0;
        upd_empty();
        step(1);
        check("E old_words", got_data.size() - got_base, 3);
        for (int i = 0; i < 3; i++)
            if (got_base + i < got_data.size())
                check($sformatf("E old w%0d last", i), got_last[got_base + i], 0);
        check("E old_done", done_count - done_base, 0);
        fq.delete();
        fill_random(4);
        launch(3);
        empty_gate = 1'b0;
        m_ready_i = 1'b1;
        upd_empty();
        step(2);
        hold_en = 1'b1;
        wait_done(200, "E");
        check_words("E");

        // F: reset mid-frame
        fill_random(32);
        launch(31);
        step(6);
        hold_en = 1'b0;
        rst_n_i = 1'b0;
        step(1);
        rst_n_i = 1'b1;
        check("F m_valid", m_valid_o, 0);
        check("F m_data", m_data_o, 0);
        check("F m_byte_en", m_byte_en_o, 0);
        check("F m_last", m_last_o, 0);
        check("F busy", busy_o, 0);
        check("F done", done_o, 0);
        check("F rd_en", fifo_rd_en_o, 0);
        rd_base = rd_count;
        step(10);
        check("F no_reads", rd_count - rd_base, 0);
        check("F idle", busy_o, 0);
        fq.delete();
        upd_empty();
        step(1);
        hold_en = 1'b1;

        // G: single-byte frame
        fill_random(1);
        launch(0);
        wait_done(50, "G");
        check_words("G");
        check("G rd_count", rd_count - rd_base, 1);

        check("rd_while_empty", empty_viol, 0);
        check("hold_stable", hold_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
